// File: rtl/branch_predictor_if.sv
// Fetch/decode-side bundle for the branch predictor: predict request/response,
// resolved-branch training, and mispredict statistics.
interface branch_predictor_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        pred_hit;
    logic [31:0] pred_target;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;

    logic        mispredict;
    logic [31:0] mispredict_cnt;

    modport master (
        output fetch_valid, fetch_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        input  pred_taken, pred_hit, pred_target,
        input  mispredict, mispredict_cnt
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        output pred_taken, pred_hit, pred_target,
        output mispredict, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency prediction from
// the fetch PC, training from decode-resolved branches, saturating mispredict count.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_STRONG_NT = 2'b00;
    localparam ctr_t CTR_WEAK_NT   = 2'b01;
    localparam ctr_t CTR_WEAK_T    = 2'b10;
    localparam ctr_t CTR_STRONG_T  = 2'b11;

    logic [ENTRIES-1:0]            valid_q, valid_d;
    ctr_t [ENTRIES-1:0]            ctr_q, ctr_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0][31:0]      target_q, target_d;
    logic                          mispredict_q, mispredict_d;
    logic [31:0]                   mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, mis_evt;
    logic             unused_pc_lsbs;

    assign f_idx = bp.fetch_pc[IDX_W+1:2];
    assign f_tag = bp.fetch_pc[31:IDX_W+2];
    assign u_idx = bp.upd_pc[IDX_W+1:2];
    assign u_tag = bp.upd_pc[31:IDX_W+2];
    assign unused_pc_lsbs = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

    // Predict reads the registered arrays only, so a same-cycle update is not bypassed.
    assign f_hit          = bp.fetch_valid & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
    assign bp.pred_hit    = f_hit;
    assign bp.pred_taken  = f_hit & ctr_q[f_idx][1];
    assign bp.pred_target = bp.pred_taken ? target_q[f_idx] : bp.fetch_pc + 32'd4;

    assign u_hit   = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
    assign mis_evt = bp.upd_valid & (bp.upd_pred_taken != bp.upd_taken);

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
        valid_d          = valid_q;
        ctr_d            = ctr_q;
        tag_d            = tag_q;
        target_d         = target_q;
        mispredict_d     = mis_evt;
        mispredict_cnt_d = mispredict_cnt_q;

        if (mis_evt && (mispredict_cnt_q != '1)) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end

        if (bp.upd_valid) begin
            if (u_hit) begin
                if (bp.upd_taken) begin
                    if (ctr_q[u_idx] != CTR_STRONG_T) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                    target_d[u_idx] = bp.upd_target;
                end else if (ctr_q[u_idx] != CTR_STRONG_NT) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // Allocation replaces whatever branch previously aliased onto this slot.
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = bp.upd_target;
                ctr_d[u_idx]    = CTR_WEAK_T;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q          <= '0;
            ctr_q            <= {ENTRIES{CTR_WEAK_NT}};
            mispredict_q     <= 1'b0;
            mispredict_cnt_q <= '0;
        end else begin
            valid_q          <= valid_d;
            ctr_q            <= ctr_d;
            mispredict_q     <= mispredict_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // NOTE: tag and target storage is left unreset; the cleared valid bits make stale contents unreachable.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign bp.mispredict     = mispredict_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage branch predictor. It supplies the prediction that the decode-stage branch decision unit later checks, closing the prediction loop.
- Direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Predicts taken/not-taken and the next PC combinationally from the fetch PC.
- Is trained by the resolved outcome (take_branch and target) reported from decode.
- Keeps a running count of mispredictions for performance debug.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 2..256
IDX_W, $clog2(ENTRIES), index width (derived, not overridden)
TAG_W, 30-IDX_W, tag width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
fetch_valid  input  1  fetch_pc is a real fetch this cycle
fetch_pc  input  32  PC being fetched (word aligned)
pred_taken  output  1  prediction: branch taken
pred_hit  output  1  fetch_pc matched a valid BTB entry
pred_target  output  32  predicted next PC
upd_valid  input  1  a branch resolved in decode this cycle
upd_pc  input  32  PC of the resolved branch
upd_taken  input  1  actual outcome (take_branch)
upd_target  input  32  actual taken target
upd_pred_taken  input  1  prediction that was made for this branch
mispredict  output  1  registered: previous-cycle update was mispredicted
mispredict_cnt  output  32  saturating mispredict count

Behaviour:
Reset:
- Synchronous, while rst_n=0 at a clk edge.
- Clears all valid bits and sets all counters to 2'b01 (weakly not-taken).
- Clears mispredict and mispredict_cnt to 0.
- Tags and targets do not need resetting.
- Reset wins over a simultaneous update.

Addressing:
- index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- pc[1:0] is ignored.

Predict path (combinational, zero latency):
- hit = fetch_valid & valid[index] & (tag[index] == fetch tag).
- pred_hit = hit; pred_taken = hit & ctr[index][1].
- pred_target = pred_taken ? target[index] : fetch_pc + 32'd4. The add wraps modulo 2^32.
- When fetch_valid=0: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4.

Update path:
- Acts on the clk edge when upd_valid=1 and rst_n=1.
- Entry hit (valid and tag match):
  - taken: ctr = ctr==11 ? 11 : ctr+1; target written with upd_target.
  - not taken: ctr = ctr==00 ? 00 : ctr-1; target unchanged.
- Entry miss, taken: allocate. Set valid=1, write tag and target, set ctr=2'b10. Any aliasing entry is overwritten.
- Entry miss, not taken: no BTB change.

Same-cycle predict and update to the same index:
- The predict read returns the pre-update contents; there is no bypass.
- The new contents are visible to predicts from the next cycle.

Mispredict tracking:
- Mispredict event e = upd_valid & (upd_pred_taken != upd_taken).
- The mispredict register is loaded with e every cycle, so it is a one-cycle pulse one cycle after the update.
- mispredict_cnt increments on e and saturates at 32'hFFFF_FFFF.
- Target mismatches on correctly predicted taken branches are not counted; decode handles redirect.

upd_valid=0: no state change except mispredict going to 0.

Test Plan:
1. Reset, then fetch_pc=0x100, fetch_valid=1 -> pred_hit=0, pred_taken=0, pred_target=0x104. mispredict_cnt=0.
2. Update pc=0x100, taken, target=0x200, pred_taken=0. Next cycle fetch 0x100 -> pred_hit=1, pred_taken=1 (ctr=10), pred_target=0x200. mispredict=1 for one cycle; cnt=1.
3. Two further taken updates at 0x100 -> ctr=11, stays 11. Then one not-taken update -> ctr=10, still predicts taken. A second not-taken update -> ctr=01, pred_taken=0, pred_target=0x104.
4. Alias test, ENTRIES=16: update pc=0x140 (index 0, tag 5) taken, target=0x300. Fetch 0x100 -> hit=0. Fetch 0x140 -> target 0x300. Not-taken update to an unallocated pc=0x180 -> BTB unchanged.
5. Same-cycle update (0x100 taken, target 0x400) and fetch of 0x100 -> that cycle shows the old target. The following cycle shows 0x400.
6. Assert rst_n=0 for one cycle after training, while upd_valid=1 -> all entries invalid, cnt=0, mispredict=0. Force cnt near max -> saturates at 0xFFFFFFFF. fetch_pc=0xFFFFFFFC with a miss -> pred_target=0x00000000.
